// File: rtl/mem_pkg.sv
// Shared definitions for the block-RAM write/read controller and its readback checker.
// The write pattern puts addr+1 low-order ones at each address.
package mem_pkg;

  localparam int DATA_WIDTH = 16;
  localparam int ADDR_WIDTH = 4;
  localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = 4'b1111;

  typedef enum logic [2:0] {
    CHK_IDLE  = 3'd0,
    CHK_WAIT  = 3'd1,
    CHK_CMP   = 3'd2,
    CHK_TRACK = 3'd3,
    CHK_DONE  = 3'd4
  } chk_state_e;

  // The shift amount is one bit wider than the address so the top address yields all ones.
  function automatic logic [DATA_WIDTH-1:0] expected_word(input logic [ADDR_WIDTH-1:0] addr);
    logic [ADDR_WIDTH:0] sh;
    sh = {1'b0, addr} + {{ADDR_WIDTH{1'b0}}, 1'b1};
    return ~({DATA_WIDTH{1'b1}} << sh);
  endfunction

endpackage

// File: rtl/mem_pattern_gen.sv
// Combinational address-to-expected-word mapping.
// The RAM writer reuses it to generate its write data.
module mem_pattern_gen
  import mem_pkg::*;
(
  input  logic [ADDR_WIDTH-1:0] addr_i,
  output logic [DATA_WIDTH-1:0] exp_o
);

  assign exp_o = expected_word(addr_i);

endmodule

// File: rtl/mem_readback_checker.sv
// Passive readback monitor: compares each distinct RAM read against the write pattern.
// It counts passes and failures, and captures the first failure.
//
// state | meaning
// IDLE  | no read in progress
// WAIT  | address captured, waiting READ_LATENCY cycles for douta
// CMP   | compare douta against the pattern, update counts once per address
// TRACK | address compared, waiting for the next distinct read address
// DONE  | all addresses checked, results frozen until cleared
module mem_readback_checker
  import mem_pkg::*;
#(
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk_in,
  input  logic                  rst,
  input  logic                  locked,
  input  logic                  clr,
  input  logic                  ena,
  input  logic                  wea,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] douta,
  output logic [2:0]            state,
  output logic [4:0]            pass_cnt,
  output logic [4:0]            fail_cnt,
  output logic [ADDR_WIDTH-1:0] first_fail_addr,
  output logic [DATA_WIDTH-1:0] first_fail_data,
  output logic                  fail_seen,
  output logic                  done,
  output logic                  pass
);

  localparam logic [1:0] LAT_LAST = 2'(READ_LATENCY - 1);

  chk_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
  logic [1:0]            lat_q, lat_d;
  logic [ADDR_MAX:0]     checked_q, checked_d;
  logic [4:0]            pass_cnt_q, pass_cnt_d;
  logic [4:0]            fail_cnt_q, fail_cnt_d;
  logic [ADDR_WIDTH-1:0] ff_addr_q, ff_addr_d;
  logic [DATA_WIDTH-1:0] ff_data_q, ff_data_d;
  logic                  fail_seen_q, fail_seen_d;
  logic [DATA_WIDTH-1:0] exp_word;
  logic                  rd;

  assign rd = ena && !wea;

  mem_pattern_gen u_pattern_gen (
    .addr_i (cur_addr_q),
    .exp_o  (exp_word)
  );

  always_comb begin
    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    lat_d       = lat_q;
    checked_d   = checked_q;
    pass_cnt_d  = pass_cnt_q;
    fail_cnt_d  = fail_cnt_q;
    ff_addr_d   = ff_addr_q;
    ff_data_d   = ff_data_q;
    fail_seen_d = fail_seen_q;

    if (!locked || clr) begin
      state_d     = CHK_IDLE;
      cur_addr_d  = '0;
      lat_d       = '0;
      checked_d   = '0;
      pass_cnt_d  = '0;
      fail_cnt_d  = '0;
      ff_addr_d   = '0;
      ff_data_d   = '0;
      fail_seen_d = 1'b0;
    end else begin
      case (state_q)
        CHK_IDLE: begin
          if (rd) begin
            cur_addr_d = addr;
            lat_d      = '0;
            state_d    = CHK_WAIT;
          end
        end
        CHK_WAIT: begin
          if (!rd) begin
            state_d = CHK_IDLE;
          end else if (addr != cur_addr_q) begin
            cur_addr_d = addr;
            lat_d      = '0;
          end else if (lat_q == LAT_LAST) begin
            state_d = CHK_CMP;
          end else begin
            lat_d = lat_q + 2'd1;
          end
        end
        CHK_CMP: begin
          // The bitmap keeps re-reads of an address from being counted twice.
          if (!checked_q[cur_addr_q]) begin
            checked_d[cur_addr_q] = 1'b1;
            if (douta == exp_word) begin
              pass_cnt_d = pass_cnt_q + 5'd1;
            end else begin
              fail_cnt_d = fail_cnt_q + 5'd1;
              if (!fail_seen_q) begin
                ff_addr_d   = cur_addr_q;
                ff_data_d   = douta;
                fail_seen_d = 1'b1;
              end
            end
          end
          state_d = (&checked_d) ? CHK_DONE : CHK_TRACK;
        end
        CHK_TRACK: begin
          if (!ena) begin
            state_d = CHK_IDLE;
          end else if (rd && (addr != cur_addr_q)) begin
            cur_addr_d = addr;
            lat_d      = '0;
            state_d    = CHK_WAIT;
          end
        end
        CHK_DONE: state_d = CHK_DONE;
        default:  state_d = CHK_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      state_q     <= CHK_IDLE;
      cur_addr_q  <= '0;
      lat_q       <= '0;
      checked_q   <= '0;
      pass_cnt_q  <= '0;
      fail_cnt_q  <= '0;
      ff_addr_q   <= '0;
      ff_data_q   <= '0;
      fail_seen_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      lat_q       <= lat_d;
      checked_q   <= checked_d;
      pass_cnt_q  <= pass_cnt_d;
      fail_cnt_q  <= fail_cnt_d;
      ff_addr_q   <= ff_addr_d;
      ff_data_q   <= ff_data_d;
      fail_seen_q <= fail_seen_d;
    end
  end

  assign state           = state_q;
  assign pass_cnt        = pass_cnt_q;
  assign fail_cnt        = fail_cnt_q;
  assign first_fail_addr = ff_addr_q;
  assign first_fail_data = ff_data_q;
  assign fail_seen       = fail_seen_q;
  assign done            = (state_q == CHK_DONE);
  assign pass            = done && (fail_cnt_q == 5'd0);

endmodule

// File: doc/mem_readback_checker.md
Name: mem_readback_checker

Overview:
- Passive monitor on the read side of the 16x16 block-RAM interface driven by the memory write/read controller.
- Snoops ena/wea/addr and the RAM read-data port and compares every read word against the write pattern (address i holds i+1 low-order ones).
- Counts passes and failures, captures the first failing address and data, and flags done after all 16 addresses are checked.
- Feeds LED/segment display logic and the board-level pass indicator.

Parameters:
- DATA_WIDTH, 16, RAM word width.
- ADDR_WIDTH, 4, RAM address width.
- ADDR_MAX, 4'b1111, last address; done is raised when 0..ADDR_MAX are all checked.
- READ_LATENCY, 1, clk_in cycles from address presentation to valid douta (range 1..3).

Ports:
- clk_in  input  1  system clock; same clock as the RAM and the controller.
- rst  input  1  asynchronous, active-low reset.
- locked  input  1  clock-manager lock; low acts as a synchronous clear.
- clr  input  1  synchronous clear of results; one-cycle pulse.
- ena  input  1  RAM enable from the controller.
- wea  input  1  RAM write enable from the controller.
- addr  input  ADDR_WIDTH  RAM address from the controller.
- douta  input  DATA_WIDTH  RAM read data.
- state  output  3  FSM state code for debug/LEDs.
- pass_cnt  output  5  number of addresses that matched (0..16).
- fail_cnt  output  5  number of addresses that mismatched (0..16).
- first_fail_addr  output  ADDR_WIDTH  address of the first mismatch.
- first_fail_data  output  DATA_WIDTH  douta captured at the first mismatch.
- fail_seen  output  1  set at the first mismatch; sticky.
- done  output  1  all addresses checked.
- pass  output  1  done && fail_cnt==0.

Behaviour:
- Reset and clear:
  - Asynchronous reset (rst=0), or locked=0 or clr=1 sampled at a clk_in edge, forces every output and internal register to 0.
  - This covers state=IDLE, counts, captures, the checked bitmap and the latency counter.
  - Clear has priority over any other same-cycle event.
- Read qualifier: rd = ena && !wea.
- IDLE (0):
  - On rd: cur_addr<=addr, lat<=0, go to WAIT.
- WAIT (1):
  - lat increments each cycle.
  - When lat==READ_LATENCY-1, go to CMP on the next edge.
  - If rd drops during WAIT, return to IDLE with no compare.
  - If addr changes during WAIT, restart WAIT with the new cur_addr.
- CMP (2): single cycle.
  - Expected word: exp = ~({DATA_WIDTH{1'b1}} << (cur_addr+1)), using a 5-bit shift amount. Address 0 gives 0x0001; address 15 gives 0xFFFF.
  - If checked[cur_addr] is already set: no count change (re-reads are not double-counted).
  - Otherwise set checked[cur_addr].
  - If douta==exp, increment pass_cnt.
  - If there is a mismatch, increment fail_cnt. If fail_seen==0, also capture first_fail_addr=cur_addr and first_fail_data=douta, and set fail_seen.
  - If all 16 bitmap bits are set after this update, go to DONE. Otherwise go to TRACK.
- TRACK (3):
  - Wait for rd with addr!=cur_addr, then capture it and go to WAIT.
  - If ena drops, go to IDLE; results are retained.
  - A write (wea=1) is ignored and results are retained.
- DONE (4):
  - done=1; pass=(fail_cnt==0).
  - All inputs are ignored until reset, locked low or clr.
- Invariant: pass_cnt+fail_cnt equals the popcount of checked, never exceeds 16, and the counts never wrap.
- Latency:
  - Counts update READ_LATENCY+1 edges after a new address is first seen with rd.
  - done asserts on the edge after the CMP cycle of the 16th distinct address.
- Slow read clock: the controller holds addr for many clk_in cycles, and each held address is compared exactly once.
- Unused state codes 5..7 recover to IDLE.

Decomposition:
- Shared package mem_pkg holds:
  - DATA_WIDTH, ADDR_WIDTH, ADDR_MAX;
  - state encodings CHK_IDLE, CHK_WAIT, CHK_CMP, CHK_TRACK, CHK_DONE;
  - the pattern function expected_word(addr), shared with the controller's write-data generation.
- One sub-module, mem_pattern_gen: combinational address-to-expected-word mapping, instantiated here and reusable in the writer.
- Counters and capture registers stay in the top module.

Test Plan:
- Clean pass:
  - Stimulus: reset, then drive a read sweep of addresses 0..15, each held 6 cycles with correct douta after 1 cycle.
  - Response: pass_cnt=16, fail_cnt=0, done=1, pass=1, fail_seen=0.
- Single corruption:
  - Stimulus: address 5 returns 0x003E instead of 0x003F.
  - Response: fail_cnt=1, pass_cnt=15, first_fail_addr=5, first_fail_data=0x003E, pass=0, done=1.
- Multiple failures:
  - Stimulus: addresses 3 and 9 are corrupted.
  - Response: fail_cnt=2, and first_fail_addr stays 3.
- Re-read and write interleave:
  - Stimulus: read 0,1,1,2 (address 1 re-presented after 2 cycles), then a wea=1 cycle during TRACK.
  - Response: pass_cnt=3, no double count, state remains TRACK.
- Reset and clear mid-sweep:
  - Stimulus: rst=0 asynchronously after address 7, between clock edges. Then repeat the sweep and pulse clr at address 4; separately drop locked for one cycle.
  - Response:
    - All outputs are 0 immediately on rst=0.
    - clr and locked=0 clear everything on the next edge.
    - After a fresh full sweep, pass=1.
- Latency:
  - Stimulus: READ_LATENCY=3 and a data-valid model delayed 3 cycles.
  - Response: all 16 addresses pass, and the CMP cycle occurs exactly 4 edges after each address change.
